// File: rtl/bicubic_upsample_sched_if.sv
`timescale 1ns/1ps
// Bundle of the requester, core and response handshakes around the bicubic scheduler.
// The master view belongs to the scheduler; the slave view is its environment.
interface bicubic_upsample_sched_if #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int NREQ          = 3,
    parameter int ID_WIDTH      = 2
);
    localparam int WIN_W = 16 * CHANNEL_WIDTH;

    // Requester side: one window slice per requester
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIN_W-1:0] req_win;

    // Shared upsample core
    logic                  core_req_valid;
    logic                  core_req_ready;
    logic [WIN_W-1:0]      core_win;
    logic                  core_rsp_valid;
    logic                  core_rsp_ready;
    logic [WIN_W-1:0]      core_rsp_data;

    // Tagged response
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_WIDTH-1:0]   rsp_id;
    logic [WIN_W-1:0]      rsp_data;
    logic [15:0]           done_cnt;

    modport master (
        input  req_valid, req_win,
        output req_ready,
        output core_req_valid, core_win, core_rsp_ready,
        input  core_req_ready, core_rsp_valid, core_rsp_data,
        output rsp_valid, rsp_id, rsp_data, done_cnt,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_win,
        input  req_ready,
        input  core_req_valid, core_win, core_rsp_ready,
        output core_req_ready, core_rsp_valid, core_rsp_data,
        input  rsp_valid, rsp_id, rsp_data, done_cnt,
        output rsp_ready
    );
endinterface

// File: rtl/bicubic_upsample_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler time-sharing one bicubic 4x4 upsample core among NREQ window
// requesters; one transaction in flight, results returned tagged with the requester id.
module bicubic_upsample_sched #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int NREQ          = 3,
    parameter int ID_WIDTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    bicubic_upsample_sched_if.master bus
);
    localparam int WIN_W = 16 * CHANNEL_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] ptr_q, id_q;
    logic [WIN_W-1:0]    win_q, res_q;
    logic [15:0]         done_q;

    logic                any_req;
    logic [ID_WIDTH-1:0] winner, ptr_next;
    logic [WIN_W-1:0]    win_sel;
    logic                grant, capture, complete;

    logic [NREQ-1:0]     req_ready;
    logic                core_req_valid, core_rsp_ready, rsp_valid;

    // Winner is the first requesting index at or above ptr_q, wrapping modulo NREQ.
    always_comb begin
        logic [ID_WIDTH-1:0] cand;
        // NOTE: every comb output gets a default before any branch so no latch is inferred.
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = ID_WIDTH'((int'(ptr_q) + off) % NREQ);
            if (!any_req && bus.req_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        win_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_WIDTH'(i)) win_sel = bus.req_win[i*WIN_W +: WIN_W];
        end
    end

    assign ptr_next = (winner == ID_WIDTH'(NREQ - 1)) ? '0 : winner + ID_WIDTH'(1);

    assign grant    = (state_q == S_IDLE) && any_req;
    assign capture  = ((state_q == S_ISSUE) && bus.core_req_ready && bus.core_rsp_valid) ||
                      ((state_q == S_WAIT)  && bus.core_rsp_valid);
    assign complete = (state_q == S_RESP) && bus.rsp_ready;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: begin
                if (bus.core_req_ready) state_d = bus.core_rsp_valid ? S_RESP : S_WAIT;
            end
            S_WAIT:  if (bus.core_rsp_valid) state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready      = '0;
        core_req_valid = 1'b0;
        core_rsp_ready = 1'b0;
        rsp_valid      = 1'b0;
        case (state_q)
            S_IDLE:  if (any_req) req_ready = NREQ'(1) << winner;
            S_ISSUE: begin
                core_req_valid = 1'b1;
                core_rsp_ready = 1'b1;
            end
            S_WAIT:  core_rsp_ready = 1'b1;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Window, id, result and completion counter
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too, because core_win/rsp_data must read 0 out of reset.
        if (rst) begin
            ptr_q  <= '0;
            id_q   <= '0;
            win_q  <= '0;
            res_q  <= '0;
            done_q <= '0;
        end else begin
            if (grant) begin
                win_q <= win_sel;
                id_q  <= winner;
                ptr_q <= ptr_next;
            end
            if (capture)  res_q  <= bus.core_rsp_data;
            if (complete) done_q <= done_q + 16'd1;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.core_req_valid = core_req_valid;
    assign bus.core_rsp_ready = core_rsp_ready;
    assign bus.core_win       = win_q;
    assign bus.rsp_valid      = rsp_valid;
    assign bus.rsp_id         = id_q;
    assign bus.rsp_data       = res_q;
    assign bus.done_cnt       = done_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

    a_resp_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_RESP && !bus.rsp_ready) |=>
        (state_q == S_RESP && $stable(res_q) && $stable(id_q)));
endmodule
